// File: rtl/nibble_alu_sequencer.sv
// rtl/nibble_alu_sequencer.sv - start/done sequencer driving a 4-bit nibble ALU over a WIDTH-bit word
// Optional result flags (rsp_zero, rsp_neg) are built when NIBBLE_SEQ_FLAGS_EN is defined.
module nibble_alu_sequencer #(
  parameter int WIDTH = 32,
  parameter int OP_W  = 4,
  parameter int CNT_W = $clog2(WIDTH/4)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_word1,
  input  logic [WIDTH-1:0] req_word2,
  input  logic [OP_W-1:0]  req_op,
  input  logic             req_carry_in,
  output logic [3:0]       alu_d1,
  output logic [3:0]       alu_d2,
  output logic [OP_W-1:0]  alu_op,
  output logic             alu_carry_in,
  input  logic [3:0]       alu_res,
  input  logic             alu_carry_out,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_carry,
  output logic             busy
`ifdef NIBBLE_SEQ_FLAGS_EN
  ,
  output logic             rsp_zero,
  output logic             rsp_neg
`endif
);

  localparam int NIB = WIDTH / 4;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NIB - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] op1_q, op1_d;
  logic [WIDTH-1:0] op2_q, op2_d;
  logic [OP_W-1:0]  op_q, op_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             rsp_carry_q, rsp_carry_d;
  logic             zero_q, zero_d;
  logic             neg_q, neg_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      op1_q       <= '0;
      op2_q       <= '0;
      op_q        <= '0;
      result_q    <= '0;
      rsp_carry_q <= 1'b0;
      zero_q      <= 1'b0;
      neg_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      carry_q     <= carry_d;
      op1_q       <= op1_d;
      op2_q       <= op2_d;
      op_q        <= op_d;
      result_q    <= result_d;
      rsp_carry_q <= rsp_carry_d;
      zero_q      <= zero_d;
      neg_q       <= neg_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    carry_d     = carry_q;
    op1_d       = op1_q;
    op2_d       = op2_q;
    op_d        = op_q;
    result_d    = result_q;
    rsp_carry_d = rsp_carry_q;
    zero_d      = zero_q;
    neg_d       = neg_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          op1_d    = req_word1;
          op2_d    = req_word2;
          op_d     = req_op;
          carry_d  = req_carry_in;
          idx_d    = '0;
          result_d = '0;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        // alu_res is only sampled here, so an undriven ALU outside RUN cannot disturb state
        result_d[{idx_q, 2'b00} +: 4] = alu_res;
        carry_d = alu_carry_out;
        idx_d   = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          state_d     = S_DONE;
          rsp_carry_d = alu_carry_out;
          zero_d      = (result_d == '0);
          neg_d       = result_d[WIDTH-1];
        end
      end
      S_DONE: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign req_ready    = (state_q == S_IDLE);
  assign rsp_valid    = (state_q == S_DONE);
  assign busy         = (state_q == S_RUN);
  assign alu_d1       = busy ? op1_q[{idx_q, 2'b00} +: 4] : 4'h0;
  assign alu_d2       = busy ? op2_q[{idx_q, 2'b00} +: 4] : 4'h0;
  assign alu_carry_in = busy ? carry_q : 1'b0;
  assign alu_op       = op_q;
  assign rsp_result   = result_q;
  assign rsp_carry    = rsp_carry_q;

`ifdef NIBBLE_SEQ_FLAGS_EN
  assign rsp_zero = zero_q;
  assign rsp_neg  = neg_q;
`else
  logic unused_flags;
  assign unused_flags = zero_q ^ neg_q;
`endif

endmodule

// File: tb/tb_nibble_alu_sequencer.sv
// tb/tb_nibble_alu_sequencer.sv - directed self-checking bench for nibble_alu_sequencer
module tb_nibble_alu_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_word1;
  logic [31:0] req_word2;
  logic [3:0]  req_op;
  logic        req_carry_in;
  logic [3:0]  alu_d1;
  logic [3:0]  alu_d2;
  logic [3:0]  alu_op;
  logic        alu_carry_in;
  logic [3:0]  alu_res;
  logic        alu_carry_out;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic        rsp_carry;
  logic        busy;
`ifdef NIBBLE_SEQ_FLAGS_EN
  logic        rsp_zero;
  logic        rsp_neg;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Bench ALU: nibble adder with carry
  logic [4:0] alu_sum;
  assign alu_sum       = {1'b0, alu_d1} + {1'b0, alu_d2} + {4'b0, alu_carry_in};
  assign alu_res       = alu_sum[3:0];
  assign alu_carry_out = alu_sum[4];

  nibble_alu_sequencer dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_word1     (req_word1),
    .req_word2     (req_word2),
    .req_op        (req_op),
    .req_carry_in  (req_carry_in),
    .alu_d1        (alu_d1),
    .alu_d2        (alu_d2),
    .alu_op        (alu_op),
    .alu_carry_in  (alu_carry_in),
    .alu_res       (alu_res),
    .alu_carry_out (alu_carry_out),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_result    (rsp_result),
    .rsp_carry     (rsp_carry),
    .busy          (busy)
`ifdef NIBBLE_SEQ_FLAGS_EN
    ,
    .rsp_zero      (rsp_zero),
    .rsp_neg       (rsp_neg)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issues one request, checks the first RUN cycle and latency, leaves the DUT in DONE.
  task automatic run_req(input string tag, input logic [31:0] w1, input logic [31:0] w2,
                         input logic [3:0] op, input logic cin, input logic [31:0] exp_res,
                         input logic exp_carry, input logic exp_zero, input logic exp_neg);
    int lat;
    @(negedge clk);
    req_valid    = 1'b1;
    req_word1    = w1;
    req_word2    = w2;
    req_op       = op;
    req_carry_in = cin;
    @(negedge clk);
    req_valid = 1'b0;
    check({tag, "_busy"}, busy, 1);
    check({tag, "_op"}, alu_op, op);
    check({tag, "_d1"}, alu_d1, w1[3:0]);
    check({tag, "_cin"}, alu_carry_in, cin);
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, lat, 8);
    check({tag, "_result"}, rsp_result, exp_res);
    check({tag, "_carry"}, rsp_carry, exp_carry);
`ifdef NIBBLE_SEQ_FLAGS_EN
    check({tag, "_zero"}, rsp_zero, exp_zero);
    check({tag, "_neg"}, rsp_neg, exp_neg);
`else
    if (exp_zero ^ exp_neg ^ exp_zero) begin end
`endif
  endtask

  task automatic consume(input string tag);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check({tag, "_idle_ready"}, req_ready, 1);
    check({tag, "_idle_valid"}, rsp_valid, 0);
  endtask

  initial begin
    int acc [3];
    int n_acc;
    int cyc;
    reset        = 1'b1;
    req_valid    = 1'b0;
    req_word1    = '0;
    req_word2    = '0;
    req_op       = '0;
    req_carry_in = 1'b0;
    rsp_ready    = 1'b0;
    @(negedge clk);
    check("rst_req_ready", req_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_result", rsp_result, 0);
    check("rst_alu_op", alu_op, 0);
    @(negedge clk);
    reset = 1'b0;

    run_req("v1", 32'hEFFF_FFFF, 32'h1, 4'hA, 1'b0, 32'hF000_0000, 1'b0, 1'b0, 1'b1);
    consume("v1");
    check("v1_idle_d1", alu_d1, 0);
    check("v1_op_held", alu_op, 4'hA);
    run_req("v2", 32'hFFFF_FFFF, 32'h1, 4'h3, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b0);
    consume("v2");
    run_req("sub", 32'h5, 32'hFFFF_FFFC, 4'h5, 1'b1, 32'h0000_0002, 1'b1, 1'b0, 1'b0);
    consume("sub");

    // Backpressure in DONE with a pending request
    run_req("hold", 32'h1, 32'h2, 4'h1, 1'b0, 32'h3, 1'b0, 1'b0, 1'b0);
    req_valid = 1'b1;
    req_word1 = 32'h10;
    req_word2 = 32'h20;
    req_carry_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_result", rsp_result, 32'h3);
      check("hold_req_ready", req_ready, 0);
      check("hold_valid", rsp_valid, 1);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("hold_to_idle", req_ready, 1);
    @(negedge clk);
    req_valid = 1'b0;
    check("hold_pending_busy", busy, 1);
    check("hold_pending_ready", req_ready, 0);
    cyc = 0;
    while (!rsp_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("hold_pending_lat", cyc, 8);
    check("hold_pending_result", rsp_result, 32'h30);
    consume("hold2");

    // Reset while nibble 3 is in flight
    @(negedge clk);
    req_valid = 1'b1;
    req_word1 = 32'hFFFF_0FFF;
    req_word2 = 32'h2;
    req_op    = 4'h7;
    req_carry_in = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_cin_idx3", alu_carry_in, 1);
    check("mid_d1_idx3", alu_d1, 4'h0);
    #1 reset = 1'b1;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ready", req_ready, 1);
    check("mid_rst_valid", rsp_valid, 0);
    check("mid_rst_result", rsp_result, 0);
    check("mid_rst_cin", alu_carry_in, 0);
    check("mid_rst_op", alu_op, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("post_rst_ready", req_ready, 1);
    repeat (10) @(negedge clk);
    check("post_rst_no_rsp", rsp_valid, 0);
    run_req("reissue", 32'hFFFF_0FFF, 32'h2, 4'h7, 1'b0, 32'hFFFF_1001, 1'b0, 1'b0, 1'b1);
    consume("reissue");

    // Back-to-back with the consumer always ready
    @(negedge clk);
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    req_word1 = 32'h1;
    req_word2 = 32'h1;
    n_acc = 0;
    cyc = 0;
    acc[0] = 0; acc[1] = 0; acc[2] = 0;
    while (n_acc < 3 && cyc < 60) begin
      if (req_ready) begin
        acc[n_acc] = cyc;
        n_acc++;
      end
      @(negedge clk);
      cyc++;
    end
    req_valid = 1'b0;
    check("b2b_count", n_acc, 3);
    check("b2b_gap1", acc[1] - acc[0], 10);
    check("b2b_gap2", acc[2] - acc[1], 10);
    repeat (12) @(negedge clk);
    check("b2b_final_idle", req_ready, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
